lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/isa_types.sv | 52 +++++
 rtl/lsu_lane_align.sv | 69 ++++++
 rtl/lsu_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_types.sv
`default_nettype none
// ============================================================================
// Module      : isa_types (package)
// Description : Shared ISA-level types for the load/store unit: default data
//               width, access width encoding, fault codes, LSU state
//               encoding and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_types;

    localparam int XLEN = 32;

    // Successor to write_width_t; encoding value is log2 of the byte count.
    typedef enum logic [1:0] {
        ACC_BYTE   = 2'd0,
        ACC_HALF   = 2'd1,
        ACC_WORD   = 2'd2,
        ACC_DOUBLE = 2'd3
    } access_width_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_TIMEOUT    = 2'd2
    } fault_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // An access is misaligned when the address is not a multiple of its
    // size, or when a double is requested on a 32-bit datapath.
    function automatic logic is_misaligned(input access_width_t w,
                                           input logic [2:0]    addr_lo,
                                           input logic          xlen64);
        logic r;
        r = 1'b0;
        case (w)
            ACC_BYTE:   r = 1'b0;
            ACC_HALF:   r = addr_lo[0];
            ACC_WORD:   r = |addr_lo[1:0];
            ACC_DOUBLE: r = !xlen64 || (|addr_lo);
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane alignment.
//               Store mode (i_load=0): mask i_data to the access width and
//               shift it left into its byte lane; bytes outside the lane are 0.
//               Load mode (i_load=1): shift the bus word right by the lane
//               offset, mask to the access width, then sign- or zero-extend.
// Ports       : i_load     - 1 = load path, 0 = store path
//               i_width    - access width
//               i_unsigned - zero-extend loads when 1
//               i_offset   - byte offset within the bus word
//               i_data     - right-aligned store data or full bus read word
//               o_data     - lane-shifted store data or extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import isa_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic                         i_load,
    input  access_width_t                i_width,
    input  logic                         i_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]    i_offset,
    input  logic [XLEN-1:0]              i_data,
    output logic [XLEN-1:0]              o_data
);

    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_field;
    logic            w_sign;

    always_comb begin
        w_mask    = '1;
        w_sign    = 1'b0;
        w_shifted = i_load ? (i_data >> {i_offset, 3'b000}) : i_data;
        case (i_width)
            ACC_BYTE: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_shifted[7];
            end
            ACC_HALF: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            ACC_WORD: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                // Full-width double: nothing to extend, signedness irrelevant.
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
        w_field = w_shifted & w_mask;
        if (!i_load) begin
            o_data = w_field << {i_offset, 3'b000};
        end else if (i_unsigned || !w_sign) begin
            o_data = w_field;
        end else begin
            o_data = w_field | ~w_mask;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit controller. Accepts one hart access at a
//               time, checks alignment, issues a single bus request with lane
//               byte enables, collects read data and returns a one-cycle
//               completion pulse with extended load data or a fault code.
// Config      : LSU_TIMEOUT_EN - when defined, a counter bounds the time
//               spent in ISSUE+WAIT to TIMEOUT_CYCLES and responds with
//               FAULT_TIMEOUT; when undefined the unit waits indefinitely.
// Ports       : clk, reset (async, active-high)
//               req_*  - hart request channel (valid/ready handshake)
//               resp_* - completion pulse, load data, fault code
//               mem_*  - bus request (valid/ready) and read return
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import isa_types::*;
#(
    parameter int XLEN           = isa_types::XLEN,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_store,
    input  access_width_t        req_width,
    input  logic                 req_unsigned,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output fault_t               resp_fault,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("lsu_ctrl: XLEN must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t       r_state;
    logic             r_is_store;
    access_width_t    r_width;
    logic             r_unsigned;
    logic [OFFW-1:0]  r_off;

    logic             r_mem_req_valid;
    logic             r_mem_we;
    logic [XLEN-1:0]  r_mem_addr;
    logic [NB-1:0]    r_mem_be;
    logic [XLEN-1:0]  r_mem_wdata;

    logic             r_resp_valid;
    logic [XLEN-1:0]  r_resp_rdata;
    fault_t           r_resp_fault;

    logic             w_req_ready;
    logic             w_accept;
    logic             w_misaligned;
    logic [OFFW-1:0]  w_req_off;
    logic [NB-1:0]    w_be;
    logic [XLEN-1:0]  w_st_data;
    logic [XLEN-1:0]  w_ld_data;
    logic             w_tmo;

    // Gated by reset so the port reads 0 while reset is held and 1 in the
    // very first cycle after it is released.
    assign w_req_ready  = (r_state == IDLE) && !reset;
    assign w_accept     = req_valid && w_req_ready;
    assign w_req_off    = req_addr[OFFW-1:0];
    assign w_misaligned = is_misaligned(req_width, req_addr[2:0], XLEN == 64);

    always_comb begin
        w_be = '0;
        case (req_width)
            ACC_BYTE: w_be = NB'(4'b0001);
            ACC_HALF: w_be = NB'(4'b0011);
            ACC_WORD: w_be = NB'(4'b1111);
            default:  w_be = '1;
        endcase
        w_be = w_be << w_req_off;
    end

    // Store path works on the live request so it can be registered on accept.
    lsu_lane_align #(.XLEN(XLEN)) u_store_align (
        .i_load     (1'b0),
        .i_width    (req_width),
        .i_unsigned (req_unsigned),
        .i_offset   (w_req_off),
        .i_data     (req_wdata),
        .o_data     (w_st_data)
    );

    // Load path works on the latched request and the live bus data.
    lsu_lane_align #(.XLEN(XLEN)) u_load_align (
        .i_load     (1'b1),
        .i_width    (r_width),
        .i_unsigned (r_unsigned),
        .i_offset   (r_off),
        .i_data     (mem_rdata),
        .o_data     (w_ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Fires during the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT.
    assign w_tmo = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_is_store      <= 1'b0;
            r_width         <= ACC_BYTE;
            r_unsigned      <= 1'b0;
            r_off           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_be        <= '0;
            r_mem_wdata     <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_fault    <= FAULT_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_store <= req_is_store;
                        r_width    <= req_width;
                        r_unsigned <= req_unsigned;
                        r_off      <= w_req_off;
                        if (w_misaligned) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_fault <= FAULT_MISALIGNED;
                        end else begin
                            r_state         <= ISSUE;
                            r_mem_req_valid <= 1'b1;
                            r_mem_we        <= req_is_store;
                            r_mem_addr      <= {req_addr[XLEN-1:OFFW], OFFW'(0)};
                            r_mem_be        <= w_be;
                            r_mem_wdata     <= w_st_data;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        if (r_is_store) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_fault <= FAULT_NONE;
                        end else if (mem_rvalid) begin
                            // Read data returned together with the accept.
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_ld_data;
                            r_resp_fault <= FAULT_NONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else if (w_tmo) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= RESP;
                        r_resp_valid    <= 1'b1;
                        r_resp_rdata    <= '0;
                        r_resp_fault    <= FAULT_TIMEOUT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_ld_data;
                        r_resp_fault <= FAULT_NONE;
                    end else if (w_tmo) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_fault <= FAULT_TIMEOUT;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_fault <= FAULT_NONE;
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_be     <= '0;
                    r_mem_wdata  <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = w_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_fault    = r_resp_fault;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_be        = r_mem_be;
    assign mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl. Instantiates a 32-bit and a
//               64-bit unit on shared request/bus inputs (each with its own
//               req_valid) and checks them against a byte-level model of the
//               alignment, lane and extension rules. Honours LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import isa_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid32, req_valid64;
    logic          req_is_store, req_unsigned;
    access_width_t req_width;
    logic [63:0]   req_addr, req_wdata, mem_rdata;
    logic          mem_req_ready, mem_rvalid;

    logic rr32, rv32, mv32, we32;
    logic [31:0] rd32, ma32, mw32;
    logic [3:0]  be32;
    fault_t      f32;
    logic rr64, rv64, mv64, we64;
    logic [63:0] rd64, ma64, mw64;
    logic [7:0]  be64;
    fault_t      f64;

    lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(15)) d32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid32), .req_ready(rr32), .req_is_store(req_is_store),
        .req_width(req_width), .req_unsigned(req_unsigned),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_rdata(rd32), .resp_fault(f32),
        .mem_req_valid(mv32), .mem_req_ready(mem_req_ready), .mem_we(we32),
        .mem_addr(ma32), .mem_be(be32), .mem_wdata(mw32),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    lsu_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(15)) d64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid64), .req_ready(rr64), .req_is_store(req_is_store),
        .req_width(req_width), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_rdata(rd64), .resp_fault(f64),
        .mem_req_valid(mv64), .mem_req_ready(mem_req_ready), .mem_we(we64),
        .mem_addr(ma64), .mem_be(be64), .mem_wdata(mw64),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Observation view of whichever unit is under test.
    logic        sel64;
    logic        o_req_ready, o_resp_valid, o_mem_req_valid, o_mem_we;
    logic [63:0] o_resp_rdata, o_mem_addr, o_mem_wdata, o_mem_be;
    fault_t      o_fault;
    assign o_req_ready     = sel64 ? rr64 : rr32;
    assign o_resp_valid    = sel64 ? rv64 : rv32;
    assign o_mem_req_valid = sel64 ? mv64 : mv32;
    assign o_mem_we        = sel64 ? we64 : we32;
    assign o_resp_rdata    = sel64 ? rd64 : {32'h0, rd32};
    assign o_mem_addr      = sel64 ? ma64 : {32'h0, ma32};
    assign o_mem_wdata     = sel64 ? mw64 : {32'h0, mw32};
    assign o_mem_be        = sel64 ? {56'h0, be64} : {60'h0, be32};
    assign o_fault         = sel64 ? f64 : f32;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},     64'(o_req_ready), 64'd0);
        check({tag, " resp_valid"},    64'(o_resp_valid), 64'd0);
        check({tag, " resp_rdata"},    o_resp_rdata, 64'd0);
        check({tag, " resp_fault"},    64'(o_fault), 64'(FAULT_NONE));
        check({tag, " mem_req_valid"}, 64'(o_mem_req_valid), 64'd0);
        check({tag, " mem_we"},        64'(o_mem_we), 64'd0);
        check({tag, " mem_addr"},      o_mem_addr, 64'd0);
        check({tag, " mem_be"},        o_mem_be, 64'd0);
        check({tag, " mem_wdata"},     o_mem_wdata, 64'd0);
    endtask

    // One complete access against the model. rd = cycles mem_req_ready is held
    // low in ISSUE; rv = cycles after the bus accept until read data (0 = same
    // cycle as the accept).
    task automatic do_access(input bit is64, input bit st, input int w, input bit uns,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] rdata, input int rd, input int rv,
                             input string tag);
        int          nb, n, off, lat;
        bit          mis, issuing;
        logic [63:0] busmask, e_be, e_wd, e_ld, e_addr, e_rdata;
        nb      = is64 ? 8 : 4;
        n       = 1 << w;
        busmask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        addr    = addr & busmask;
        off     = int'(addr % 64'(nb));
        mis     = (n > nb) || ((addr % 64'(n)) != 0);
        e_addr  = addr - 64'(off);
        e_be = '0; e_wd = '0; e_ld = '0;
        for (int i = 0; i < nb; i++) begin
            if (i >= off && i < off + n) begin
                e_be[i]      = 1'b1;
                e_wd[8*i+:8] = wdata[8*(i-off)+:8];
            end
        end
        if (!mis) begin
            for (int i = 0; i < n; i++) e_ld[8*i+:8] = rdata[8*(off+i)+:8];
            if (!uns && e_ld[8*n-1])
                for (int i = n; i < nb; i++) e_ld[8*i+:8] = 8'hFF;
        end
        e_rdata = (mis || st) ? 64'd0 : e_ld;
        lat     = mis ? 1 : (st ? 2 + rd : 2 + rd + rv);

        sel64        = is64;
        req_is_store = st;
        req_width    = access_width_t'(w);
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (is64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        #1;
        check({tag, " req_ready"}, 64'(o_req_ready), 64'd1);
        tick();
        // Scramble the request inputs: the unit must be using its latched copy.
        req_valid32  = 1'b0;
        req_valid64  = 1'b0;
        req_is_store = ~st;
        req_width    = access_width_t'($urandom_range(0, 3));
        req_unsigned = ~uns;
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        for (int cyc = 1; cyc <= lat; cyc++) begin
            issuing = !mis && (cyc <= 1 + rd);
            check({tag, " resp_valid"}, 64'(o_resp_valid), 64'(cyc == lat));
            check({tag, " mem_req_valid"}, 64'(o_mem_req_valid), 64'(issuing));
            if (issuing) begin
                check({tag, " mem_we"},    64'(o_mem_we), 64'(st));
                check({tag, " mem_addr"},  o_mem_addr, e_addr);
                check({tag, " mem_be"},    o_mem_be, e_be);
                check({tag, " mem_wdata"}, o_mem_wdata, e_wd);
            end
            if (cyc == lat) begin
                check({tag, " resp_rdata"}, o_resp_rdata, e_rdata);
                check({tag, " resp_fault"}, 64'(o_fault),
                      mis ? 64'(FAULT_MISALIGNED) : 64'(FAULT_NONE));
            end
            mem_req_ready = issuing && (cyc == 1 + rd);
            mem_rvalid    = 1'b0;
            mem_rdata     = {$urandom, $urandom};
            if (!mis && !st && (cyc == 1 + rd + rv)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end else if (mis || st || (issuing && cyc < 1 + rd)) begin
                mem_rvalid = 1'($urandom_range(0, 1));
            end
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        check({tag, " resp_valid end"}, 64'(o_resp_valid), 64'd0);
        check({tag, " req_ready end"},  64'(o_req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          r64, rst_st, ru;
        int          rw, rrd, rrv;
        logic [63:0] ra, rwd, rrdat, bm;

        reset = 1'b1; sel64 = 1'b0;
        req_valid32 = 1'b0; req_valid64 = 1'b0; req_is_store = 1'b0;
        req_width = ACC_BYTE; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        tick(); tick();
        check_reset_outputs("reset32");
        sel64 = 1'b1; #1;
        check_reset_outputs("reset64");
        tick();
        reset = 1'b0; #1;
        check("post-reset req_ready64", 64'(rr64), 64'd1);
        check("post-reset req_ready32", 64'(rr32), 64'd1);
        tick();

        // Directed cases.
        do_access(0, 1, 2, 0, 64'h100, 64'hDEADBEEF, 64'h0, 0, 0, "st_word32");
        do_access(0, 0, 0, 0, 64'h103, 64'h0, 64'h8000_0000, 0, 0, "ld_byte_s32");
        do_access(0, 0, 0, 1, 64'h103, 64'h0, 64'h8000_0000, 0, 0, "ld_byte_u32");
        do_access(0, 0, 1, 0, 64'h101, 64'h0, 64'h0, 0, 0, "ld_half_mis32");
        do_access(0, 1, 1, 0, 64'h202, 64'hA5A5_1234, 64'h0, 1, 0, "st_half_off2");
        do_access(0, 0, 1, 0, 64'h302, 64'h0, 64'h8001_7FFF, 0, 2, "ld_half_hi32");
        do_access(1, 1, 3, 0, 64'h8, 64'h0123456789ABCDEF, 64'h0, 0, 0, "st_double64");
        do_access(0, 1, 3, 0, 64'h8, 64'h0123456789ABCDEF, 64'h0, 0, 0, "st_double_mis32");
        do_access(1, 0, 3, 1, 64'h10, 64'h0, 64'hF000_0000_0000_0001, 2, 1, "ld_double64");
        do_access(1, 0, 2, 0, 64'h14, 64'h0, 64'h9000_0000_0000_0000, 0, 0, "ld_word_s64");
        do_access(1, 0, 3, 0, 64'h1C, 64'h0, 64'h0, 0, 0, "ld_double_mis64");

        // Randomized accesses, mostly aligned.
        for (int k = 0; k < 40; k++) begin
            r64    = 1'($urandom_range(0, 1));
            rst_st = 1'($urandom_range(0, 1));
            ru     = 1'($urandom_range(0, 1));
            rw     = $urandom_range(0, 3);
            bm     = r64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
            ra     = {$urandom, $urandom} & bm;
            if ($urandom_range(0, 3) != 0) ra = ra & ~64'((1 << rw) - 1);
            rwd    = {$urandom, $urandom} & bm;
            rrdat  = {$urandom, $urandom} & bm;
            rrd    = $urandom_range(0, 3);
            rrv    = $urandom_range(0, 3);
            do_access(r64, rst_st, rw, ru, ra, rwd, rrdat, rrd, rrv, "rand");
        end

        // Bus never accepts.
        sel64 = 1'b0;
        req_is_store = 1'b0; req_width = ACC_WORD; req_unsigned = 1'b0;
        req_addr = 64'h200; req_valid32 = 1'b1;
        tick();
        req_valid32 = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int cyc = 1; cyc <= 16; cyc++) begin
            check("tmo resp_valid", 64'(o_resp_valid), 64'(cyc == 16));
            check("tmo mem_req_valid", 64'(o_mem_req_valid), 64'(cyc <= 15));
            if (cyc == 16) begin
                check("tmo fault", 64'(o_fault), 64'(FAULT_TIMEOUT));
                check("tmo rdata", o_resp_rdata, 64'd0);
            end
            tick();
        end
        check("tmo idle", 64'(o_req_ready), 64'd1);
`else
        for (int cyc = 1; cyc <= 100; cyc++) begin
            check("hang resp_valid", 64'(o_resp_valid), 64'd0);
            check("hang mem_req_valid", 64'(o_mem_req_valid), 64'd1);
            tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        check("hang recover req_ready", 64'(o_req_ready), 64'd1);
        tick();
`endif

        // Reset while waiting for read data; late data must be ignored.
        sel64 = 1'b0;
        req_is_store = 1'b0; req_width = ACC_WORD; req_unsigned = 1'b0;
        req_addr = 64'h400; req_valid32 = 1'b1;
        tick();
        req_valid32 = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("wait mem_req_valid", 64'(o_mem_req_valid), 64'd0);
        check("wait resp_valid", 64'(o_resp_valid), 64'd0);
        reset = 1'b1; #1;
        check_reset_outputs("midreset");
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678; #1;
        check("after reset req_ready", 64'(o_req_ready), 64'd1);
        tick();
        check("late rvalid resp_valid", 64'(o_resp_valid), 64'd0);
        mem_rvalid = 1'b0;
        tick();
        check("late rvalid resp_valid2", 64'(o_resp_valid), 64'd0);
        check("late rvalid req_ready", 64'(o_req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
